// File: rtl/uart_pkg.sv
// Shared types, framing constants and the baud divisor helper for the word UART.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  // Rounded clocks-per-bit
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: ticks on the last clock of every DIV-clock bit, held at zero when idle.
module uart_baud_gen #(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(DIV - 1));
  assign tick = run && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// 8N1 UART that sends an NBYTES-wide word MSB byte first, with a one-deep pending word buffer.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned NBYTES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_start,
  input  logic [8*NBYTES-1:0]   dbuffer,
  output logic                  tx,
  output logic                  busy,
  output logic                  pending,
  output logic                  done
);

  localparam int unsigned DIV    = calc_div(CLK_HZ, BAUD);
  localparam int unsigned W      = DATA_BITS * NBYTES;
  localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  if (DIV < 2 || FRAME_BITS != DATA_BITS + 2) begin : g_param_check
    $error("uart_word_tx: clocks per bit must be at least 2");
  end

  state_e              state_q, state_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic [W-1:0]        word_q, word_d;
  logic [W-1:0]        pend_word_q, pend_word_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic                tick;
  logic                load;
  logic                taken;
  logic [W-1:0]        load_word;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q != IDLE),
    .tick (tick)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    pend_d      = pend_q;
    done_d      = 1'b0;
    word_d      = word_q;
    pend_word_d = pend_word_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    load        = 1'b0;
    taken       = 1'b0;
    load_word   = dbuffer;

    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          load  = 1'b1;
          taken = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_idx_q != BYTE_W'(NBYTES - 1)) begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            shift_d    = word_q[W-1 -: DATA_BITS];
            word_d     = word_q << DATA_BITS;
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            done_d = 1'b1;
            if (pend_q) begin
              load      = 1'b1;
              load_word = pend_word_q;
              pend_d    = 1'b0;
            end else if (tx_start) begin
              load  = 1'b1;
              taken = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Start a new word: first byte into the shifter, start bit on the line
    if (load) begin
      shift_d    = load_word[W-1 -: DATA_BITS];
      word_d     = load_word << DATA_BITS;
      byte_idx_d = '0;
      bit_idx_d  = '0;
      state_d    = START;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end

    // A request that could not start now is parked; the latest one wins
    if (tx_start && !taken) begin
      pend_d      = 1'b1;
      pend_word_d = dbuffer;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= '0;
      pend_word_q <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      word_q      <= word_d;
      pend_word_q <= pend_word_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx against a cycle-level behavioural model of the line.
module tb_uart_word_tx;

  localparam int DIV_T  = 10;
  localparam int NB     = 3;
  localparam int WORD_C = NB * 10 * DIV_T;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_start;
  logic [23:0] dbuffer;
  logic        tx, busy, pending, done;

  logic        d_start;
  logic [23:0] d_dbuf;
  logic        d_tx, d_busy, d_pending, d_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Behavioural model state
  logic        m_active;
  int          m_t;
  logic [23:0] m_cur;
  logic        m_pend_v;
  logic [23:0] m_pend_w;
  logic        m_done;

  always #5 clk = ~clk;

  uart_word_tx #(.CLK_HZ(1000), .BAUD(100), .NBYTES(3)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .dbuffer(dbuffer),
    .tx(tx), .busy(busy), .pending(pending), .done(done)
  );

  uart_word_tx dut_def (
    .clk(clk), .rst_n(rst_n), .tx_start(d_start), .dbuffer(d_dbuf),
    .tx(d_tx), .busy(d_busy), .pending(d_pending), .done(d_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected line level t clocks into a word: 10-bit frames, MSB byte first, data LSB first
  function automatic logic exp_level(input logic [23:0] w, input int t);
    int bitnum, k, pos;
    logic [7:0] b;
    bitnum = t / DIV_T;
    k      = bitnum / 10;
    pos    = bitnum % 10;
    b      = 8'(w >> (8 * (NB - 1 - k)));
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_cur    = '0;
    m_pend_v = 1'b0;
    m_pend_w = '0;
    m_done   = 1'b0;
  endtask

  task automatic model_step();
    logic took;
    took   = 1'b0;
    m_done = 1'b0;
    if (m_active) begin
      m_t++;
      if (m_t == WORD_C) begin
        m_done = 1'b1;
        m_t    = 0;
        if (m_pend_v) begin
          m_cur    = m_pend_w;
          m_pend_v = 1'b0;
        end else if (tx_start) begin
          m_cur = dbuffer;
          took  = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end
    end else if (tx_start) begin
      m_active = 1'b1;
      m_cur    = dbuffer;
      m_t      = 0;
      took     = 1'b1;
    end
    if (tx_start && !took) begin
      m_pend_v = 1'b1;
      m_pend_w = dbuffer;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        model_step();
      end
    end
  end

  // Every cycle, compare all outputs with the model
  initial begin
    forever begin
      @(negedge clk);
      check_eq("tx_line", 32'(tx), 32'(m_active ? exp_level(m_cur, m_t) : 1'b1));
      check_eq("busy", 32'(busy), 32'(m_active));
      check_eq("pending", 32'(pending), 32'(m_pend_v));
      check_eq("done", 32'(done), 32'(m_done));
    end
  end

  task automatic send(input logic [23:0] w, output int start_cyc);
    tx_start = 1'b1;
    dbuffer  = w;
    @(negedge clk);
    tx_start  = 1'b0;
    dbuffer   = 24'($urandom);
    start_cyc = cyc;
  endtask

  task automatic wait_done(output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 2000);
    check_eq("done_timeout", 32'(n < 2000), 32'd1);
    at = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || pending !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0, s1, at, at2, cnt;
    rst_n    = 1'b0;
    tx_start = 1'b0;
    dbuffer  = '0;
    d_start  = 1'b0;
    d_dbuf   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word: done and busy fall exactly one word time after the start edge
    send(24'h123456, s0);
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_tx", 32'(tx), 32'd0);
    wait_done(at);
    check_eq("done_latency", 32'(at - s0), 32'(WORD_C));
    check_eq("busy_fall_at_done", 32'(busy), 32'd0);
    wait_idle();

    // Back-to-back through the pending buffer
    send(24'h000001, s0);
    repeat (48) @(negedge clk);
    send(24'h000002, s1);
    check_eq("b2b_pending", 32'(pending), 32'd1);
    wait_done(at);
    check_eq("b2b_done1", 32'(at - s0), 32'(WORD_C));
    check_eq("b2b_busy_held", 32'(busy), 32'd1);
    check_eq("b2b_pending_clr", 32'(pending), 32'd0);
    wait_done(at2);
    check_eq("b2b_done2", 32'(at2 - s0), 32'(2 * WORD_C));
    check_eq("b2b_busy_end", 32'(busy), 32'd0);
    wait_idle();

    // Pending overwrite: B is replaced by C
    send(24'hA1A2A3, s0);
    repeat (20) @(negedge clk);
    send(24'hB1B2B3, s1);
    repeat (20) @(negedge clk);
    send(24'hC1C2C3, s1);
    check_eq("ovw_pending", 32'(pending), 32'd1);
    wait_idle();

    // Async reset in the middle of byte 2 data with a word pending
    send(24'h5AA55A, s0);
    repeat (30) @(negedge clk);
    send(24'h0F0F0F, s1);
    repeat (110) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_tx", 32'(tx), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_pending", 32'(pending), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("post_rst_idle", 32'(tx), 32'd1);

    // Boundary patterns, then a start coinciding with the final stop exit
    send(24'h000000, s0);
    wait_idle();
    send(24'hFFFFFF, s0);
    repeat (WORD_C - 1) @(negedge clk);
    send(24'hA5C33C, s1);
    check_eq("coinc_edge", 32'(s1 - s0), 32'(WORD_C));
    check_eq("coinc_pending", 32'(pending), 32'd0);
    check_eq("coinc_busy", 32'(busy), 32'd1);
    wait_idle();

    // Random words with random spacing, often landing mid-word
    for (int i = 0; i < 12; i++) begin
      send(24'($urandom), s0);
      repeat ($urandom_range(1, 350)) @(negedge clk);
    end
    wait_idle();

    // Default parameters: start bit is 434 clocks wide
    check_eq("def_idle", 32'(d_tx), 32'd1);
    d_start = 1'b1;
    d_dbuf  = 24'hFFFFFF;
    @(negedge clk);
    d_start = 1'b0;
    cnt = 0;
    while (d_tx === 1'b0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("def_start_width", 32'(cnt), 32'd434);
    check_eq("def_busy", 32'(d_busy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
